// File: rtl/pipe_sb_pkg.sv
// Shared encodings and width helpers for the integer-pipeline register scoreboard.
package pipe_sb_pkg;

  typedef enum logic [1:0] {
    PT_NONE = 2'd0,
    PT_ALU  = 2'd1,
    PT_LD   = 2'd2,
    PT_MUL  = 2'd3
  } ptype_e;

  // Forwarding select value meaning "read the register file"; a+1 forwards from age a.
  localparam int SEL_RF = 0;

  function automatic int sel_width(input int total);
    return $clog2(total + 2);
  endfunction

  function automatic int age_width(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One architectural register's producer record: valid/type/age plus next-state and ready compare.
module sb_entry
  import pipe_sb_pkg::*;
#(
  parameter int AGE_W     = 3,
  parameter int TOTAL     = 6,
  parameter int EX_STAGES = 2,
  parameter int FLUSH_AGE = 3,
  parameter int ALU_RDY   = 2,
  parameter int LD_RDY    = 5,
  parameter int MUL_RDY   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             alloc,
  input  ptype_e           alloc_type,
  input  logic             hold_all,
  input  logic             hold_ex,
  input  logic             flush,
  output logic             valid,
  output ptype_e           ptype,
  output logic [AGE_W-1:0] age,
  output logic             ready
);

  logic             valid_d;
  ptype_e           type_d;
  logic [AGE_W-1:0] age_d;
  logic             frozen;

  assign frozen = hold_all || (hold_ex && (age < AGE_W'(EX_STAGES)));

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    valid_d = valid;
    type_d  = ptype;
    age_d   = age;
    if (flush && valid && (age < AGE_W'(FLUSH_AGE))) begin
      valid_d = 1'b0;
    end else if (alloc) begin
      // The newest producer replaces any older one, even one retiring this cycle.
      valid_d = 1'b1;
      type_d  = alloc_type;
      age_d   = '0;
    end else if (!frozen && valid) begin
      if (age < AGE_W'(TOTAL)) age_d = age + 1'b1;
      else                     valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) valid <= 1'b0;
    else     valid <= valid_d;
  end

  // NOTE: only valid is reset; type and age are never observed while the entry is invalid.
  always_ff @(posedge CLK) begin
    ptype <= type_d;
    age   <= age_d;
  end

  always_comb begin
    ready = 1'b1;
    unique case (ptype)
      PT_ALU:  ready = (age >= AGE_W'(ALU_RDY));
      PT_LD:   ready = (age >= AGE_W'(LD_RDY));
      PT_MUL:  ready = (age >= AGE_W'(MUL_RDY));
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register producer tracker: allocation decode, per-source forwarding muxes and decode stall.
module reg_scoreboard
  import pipe_sb_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int EX_STAGES  = 2,
  parameter int MEM_STAGES = 3,
  parameter int ALU_RDY    = 2,
  parameter int MUL_RDY    = 4,
  parameter int LD_RDY     = 5,
  parameter int FLUSH_AGE  = 3,
  localparam int TOTAL     = EX_STAGES + MEM_STAGES + 1,
  localparam int SEL_W     = sel_width(TOTAL),
  localparam int AGE_W     = age_width(TOTAL)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ISSUE_VALID,
  input  logic [REG_AW-1:0]         ISSUE_RD,
  input  logic [1:0]                ISSUE_TYPE,
  input  logic [NUM_SRC*REG_AW-1:0] RS_SEL,
  input  logic [NUM_SRC-1:0]        RS_USE,
  input  logic                      HOLD_ALL,
  input  logic                      HOLD_EX,
  input  logic                      FLUSH,
  output logic [NUM_SRC*SEL_W-1:0]  FWD_SEL,
  output logic [NUM_SRC*2-1:0]      SRC_TYPE,
  output logic                      STALL
);

  localparam int NUM_IDX = 2 ** REG_AW;

  logic               fire;
  logic               stall_any;
  logic [NUM_IDX-1:0] ent_valid;
  logic [NUM_IDX-1:0] ent_ready;
  ptype_e             ent_type [NUM_IDX];
  logic [AGE_W-1:0]   ent_age  [NUM_IDX];

  // STALL does not depend on fire, so gating allocation with it forms no loop.
  assign fire = ISSUE_VALID && (ISSUE_TYPE != PT_NONE) && (ISSUE_RD != '0) &&
                !STALL && !HOLD_ALL && !HOLD_EX && !FLUSH;

  // x0 and any index beyond NUM_REGS always read directly from the register file.
  assign ent_valid[0] = 1'b0;
  assign ent_ready[0] = 1'b1;
  assign ent_type[0]  = PT_NONE;
  assign ent_age[0]   = '0;

  for (genvar i = 1; i < NUM_IDX; i++) begin : g_ent
    if (i < NUM_REGS) begin : g_live
      sb_entry #(
        .AGE_W    (AGE_W),
        .TOTAL    (TOTAL),
        .EX_STAGES(EX_STAGES),
        .FLUSH_AGE(FLUSH_AGE),
        .ALU_RDY  (ALU_RDY),
        .LD_RDY   (LD_RDY),
        .MUL_RDY  (MUL_RDY)
      ) u_entry (
        .CLK       (CLK),
        .RST       (RST),
        .alloc     (fire && (ISSUE_RD == REG_AW'(i))),
        .alloc_type(ptype_e'(ISSUE_TYPE)),
        .hold_all  (HOLD_ALL),
        .hold_ex   (HOLD_EX),
        .flush     (FLUSH),
        .valid     (ent_valid[i]),
        .ptype     (ent_type[i]),
        .age       (ent_age[i]),
        .ready     (ent_ready[i])
      );
    end else begin : g_tie
      assign ent_valid[i] = 1'b0;
      assign ent_ready[i] = 1'b1;
      assign ent_type[i]  = PT_NONE;
      assign ent_age[i]   = '0;
    end
  end

  always_comb begin
    FWD_SEL   = '0;
    SRC_TYPE  = '0;
    stall_any = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      logic [REG_AW-1:0] rs;
      rs = RS_SEL[k*REG_AW +: REG_AW];
      FWD_SEL[k*SEL_W +: SEL_W] = SEL_W'(SEL_RF);
      if (ent_valid[rs]) begin
        FWD_SEL[k*SEL_W +: SEL_W] = SEL_W'(ent_age[rs]) + SEL_W'(1);
        SRC_TYPE[k*2 +: 2]        = ent_type[rs];
        if (RS_USE[k] && !ent_ready[rs]) stall_any = 1'b1;
      end
    end
  end

  assign STALL = HOLD_ALL || stall_any;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed-vector bench for reg_scoreboard with hand-computed expected forwarding/stall values.
module tb_reg_scoreboard;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ISSUE_VALID;
  logic [4:0] ISSUE_RD;
  logic [1:0] ISSUE_TYPE;
  logic [9:0] RS_SEL;
  logic [1:0] RS_USE;
  logic       HOLD_ALL;
  logic       HOLD_EX;
  logic       FLUSH;
  logic [5:0] FWD_SEL;
  logic [3:0] SRC_TYPE;
  logic       STALL;

  int n_vec = 0;
  int n_bad = 0;

  reg_scoreboard dut (
    .CLK        (CLK),
    .RST        (RST),
    .ISSUE_VALID(ISSUE_VALID),
    .ISSUE_RD   (ISSUE_RD),
    .ISSUE_TYPE (ISSUE_TYPE),
    .RS_SEL     (RS_SEL),
    .RS_USE     (RS_USE),
    .HOLD_ALL   (HOLD_ALL),
    .HOLD_EX    (HOLD_EX),
    .FLUSH      (FLUSH),
    .FWD_SEL    (FWD_SEL),
    .SRC_TYPE   (SRC_TYPE),
    .STALL      (STALL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_rs(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] use_bits);
    RS_SEL = {r1, r0};
    RS_USE = use_bits;
  endtask

  task automatic issue_tick(input logic [4:0] rd, input logic [1:0] ty);
    ISSUE_VALID = 1'b1;
    ISSUE_RD    = rd;
    ISSUE_TYPE  = ty;
    tick();
    ISSUE_VALID = 1'b0;
  endtask

  // Settles combinational outputs, then checks one source's select and type.
  task automatic chk_src(input string tag, input int k, input int fwd, input int ty);
    #1;
    check({tag, "_fwd"},  int'(FWD_SEL[k*3 +: 3]),  fwd);
    check({tag, "_type"}, int'(SRC_TYPE[k*2 +: 2]), ty);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; ISSUE_VALID = 1'b0; ISSUE_RD = '0; ISSUE_TYPE = '0;
    RS_SEL = '0; RS_USE = '0; HOLD_ALL = 1'b0; HOLD_EX = 1'b0; FLUSH = 1'b0;
    tick();
    tick();

    // Reset state: direct reads, STALL follows HOLD_ALL only.
    set_rs(5'd5, 5'd7, 2'b11);
    chk_src("rst_s0", 0, 0, 0);
    chk_src("rst_s1", 1, 0, 0);
    check("rst_stall", STALL, 0);
    HOLD_ALL = 1'b1;
    #1 check("rst_stall_hold", STALL, 1);
    HOLD_ALL = 1'b0;
    RST = 1'b0;
    set_rs(5'd0, 5'd0, 2'b00);
    tick();

    // 1: ALU producer to x5, ready from age 2, gone one cycle after age 6.
    issue_tick(5'd5, 2'd1);
    set_rs(5'd5, 5'd0, 2'b11);
    for (int a = 0; a <= 6; a++) begin
      chk_src($sformatf("t1_a%0d", a), 0, a + 1, 1);
      check($sformatf("t1_stall_a%0d", a), STALL, (a < 2) ? 1 : 0);
      tick();
    end
    chk_src("t1_done", 0, 0, 0);
    check("t1_done_stall", STALL, 0);

    // 2: load to x7 read on source 1; stalls until age 5; unused source never stalls.
    set_rs(5'd0, 5'd0, 2'b00);
    issue_tick(5'd7, 2'd2);
    set_rs(5'd0, 5'd7, 2'b10);
    for (int a = 0; a <= 6; a++) begin
      chk_src($sformatf("t2_a%0d", a), 1, a + 1, 2);
      check($sformatf("t2_stall_a%0d", a), STALL, (a < 5) ? 1 : 0);
      if (a == 0) begin
        RS_USE = 2'b00;
        #1 check("t2_nouse_stall", STALL, 0);
        RS_USE = 2'b10;
      end
      tick();
    end
    chk_src("t2_done", 1, 0, 0);

    // 3: WAW - ALU then load to x3 on consecutive cycles; only the load is visible.
    set_rs(5'd0, 5'd0, 2'b00);
    issue_tick(5'd3, 2'd1);
    issue_tick(5'd3, 2'd2);
    set_rs(5'd3, 5'd0, 2'b00);
    for (int a = 0; a <= 6; a++) begin
      chk_src($sformatf("t3_a%0d", a), 0, a + 1, 2);
      tick();
    end
    chk_src("t3_done", 0, 0, 0);

    // 4: FLUSH kills x4 (age 2), spares x9 (age 4), and blocks a same-cycle issue to x10.
    set_rs(5'd0, 5'd0, 2'b00);
    issue_tick(5'd9, 2'd1);
    tick();
    issue_tick(5'd4, 2'd1);
    tick();
    tick();
    set_rs(5'd4, 5'd9, 2'b00);
    chk_src("t4_pre_x4", 0, 3, 1);
    chk_src("t4_pre_x9", 1, 5, 1);
    FLUSH = 1'b1;
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd10; ISSUE_TYPE = 2'd1;
    tick();
    FLUSH = 1'b0;
    ISSUE_VALID = 1'b0;
    chk_src("t4_x4_killed", 0, 0, 0);
    chk_src("t4_x9_a5", 1, 6, 1);
    set_rs(5'd10, 5'd9, 2'b00);
    chk_src("t4_x10_none", 0, 0, 0);
    tick();
    chk_src("t4_x9_a6", 1, 7, 1);
    tick();
    chk_src("t4_x9_done", 1, 0, 0);

    // 5a: HOLD_ALL freezes an age-1 ALU entry and forces STALL.
    set_rs(5'd0, 5'd0, 2'b00);
    issue_tick(5'd6, 2'd1);
    tick();
    set_rs(5'd6, 5'd0, 2'b01);
    HOLD_ALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_src($sformatf("t5_hold%0d", i), 0, 2, 1);
      check($sformatf("t5_hold_stall%0d", i), STALL, 1);
      tick();
    end
    chk_src("t5_hold_end", 0, 2, 1);
    HOLD_ALL = 1'b0;
    tick();
    chk_src("t5_release", 0, 3, 1);
    check("t5_release_stall", STALL, 0);

    // 5b: HOLD_EX holds the age-1 mul (x12), advances the age-3 alu (x11), blocks issue to x13.
    set_rs(5'd0, 5'd0, 2'b00);
    issue_tick(5'd11, 2'd1);
    tick();
    issue_tick(5'd12, 2'd3);
    tick();
    HOLD_EX = 1'b1;
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd13; ISSUE_TYPE = 2'd1;
    tick();
    HOLD_EX = 1'b0;
    ISSUE_VALID = 1'b0;
    set_rs(5'd11, 5'd12, 2'b10);
    chk_src("t5_ex_x11", 0, 5, 1);
    chk_src("t5_ex_x12", 1, 2, 3);
    check("t5_ex_stall", STALL, 1);
    set_rs(5'd13, 5'd0, 2'b00);
    chk_src("t5_ex_x13", 0, 0, 0);
    set_rs(5'd11, 5'd12, 2'b10);
    for (int a = 2; a <= 4; a++) begin
      tick();
      chk_src($sformatf("t5_mul_a%0d", a), 1, a + 1, 3);
      check($sformatf("t5_mul_stall_a%0d", a), STALL, (a < 4) ? 1 : 0);
    end

    // 6: x0 is never tracked; RST mid-flight drops everything.
    set_rs(5'd0, 5'd0, 2'b00);
    repeat (8) tick();
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd0; ISSUE_TYPE = 2'd1;
    tick();
    ISSUE_VALID = 1'b0;
    set_rs(5'd0, 5'd0, 2'b11);
    chk_src("t6_x0_s0", 0, 0, 0);
    chk_src("t6_x0_s1", 1, 0, 0);
    check("t6_x0_stall", STALL, 0);
    set_rs(5'd0, 5'd0, 2'b00);
    issue_tick(5'd8, 2'd1);
    tick();
    set_rs(5'd8, 5'd0, 2'b01);
    chk_src("t6_pre_rst", 0, 2, 1);
    check("t6_pre_rst_stall", STALL, 1);
    RST = 1'b1;
    tick();
    chk_src("t6_in_rst", 0, 0, 0);
    check("t6_in_rst_stall", STALL, 0);
    RST = 1'b0;
    tick();
    chk_src("t6_post_rst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
